// File: rtl/ram_port_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_master_pkg
//  Description : Shared types and constants for the RAM port master slice.
//                Holds the command FSM state encoding and the smallest
//                response FIFO depth that still sustains one beat per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_port_master_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RBURST = 1'b1
    } state_e;

    localparam int MIN_RSP_DEPTH = 2;

endpackage : ram_port_master_pkg
`default_nettype wire

// File: rtl/ram_port_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_master_if
//  Description : Bundles the command channel, response channel and RAM port
//                of one ram_port_master instance.
//                  cmd_*  : valid/ready command (single write / read burst)
//                  rsp_*  : valid/ready read response
//                  ram_*  : byte-masked RAM port (dout registered, 1 cycle)
//                modport master : the ram_port_master side
//                modport slave  : the command source / RAM side
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_port_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 4
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BWEN_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wen;
    logic [BWEN_WIDTH-1:0] cmd_bwen;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_last;

    logic                  ram_cen;
    logic                  ram_wen;
    logic [BWEN_WIDTH-1:0] ram_bwen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_wen, cmd_bwen, cmd_addr, cmd_len, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_last,
        input  rsp_ready,
        output ram_cen, ram_wen, ram_bwen, ram_addr, ram_din,
        input  ram_dout
    );

    modport slave (
        output cmd_valid, cmd_wen, cmd_bwen, cmd_addr, cmd_len, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_last,
        output rsp_ready,
        input  ram_cen, ram_wen, ram_bwen, ram_addr, ram_din,
        output ram_dout
    );

endinterface : ram_port_master_if
`default_nettype wire

// File: rtl/ram_port_master_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rsp_fifo
//  Description : Small synchronous FIFO holding read responses. Head is read
//                straight from storage (no write-to-read bypass).
//                  clock/reset_n : clock, async active-low reset (flush)
//                  push/push_data: write one entry
//                  pop/pop_data  : remove head / head entry
//                  count/full/empty : occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module ram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  wire                         clock,
    input  wire                         reset_n,
    input  wire                         push,
    input  wire  [WIDTH-1:0]            push_data,
    input  wire                         pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        full     = (count_q == CNT_WIDTH'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
        do_pop   = pop && !empty;
        // A push into a full FIFO is legal only when the head leaves this cycle.
        do_push  = push && (!full || do_pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : ram_rsp_fifo
`default_nettype wire

// File: rtl/ram_port_master.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_master
//  Description : Initiator for one port of a byte-masked RAM with 1-cycle
//                registered read latency. Turns single writes and
//                incrementing read bursts into RAM cycles and returns read
//                data through a credit-controlled response FIFO.
//                  clock   : rising-edge clock
//                  reset_n : async active-low reset
//                  bus     : cmd / rsp channels and RAM port (master view)
//  Revision    : 1.0  initial release
// ============================================================================
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  wire               clock,
    input  wire               reset_n,
    ram_port_master_if.master bus
);
    localparam int ADDR_WIDTH    = $clog2(DEPTH);
    localparam int BWEN_WIDTH    = DATA_WIDTH / 8;
    localparam int RSP_DEPTH_EFF = (RSP_DEPTH < MIN_RSP_DEPTH) ? MIN_RSP_DEPTH : RSP_DEPTH;
    localparam int CNT_WIDTH     = $clog2(RSP_DEPTH_EFF + 1);
    localparam int FIFO_WIDTH    = DATA_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  last_q, last_d;

    logic [CNT_WIDTH-1:0]  fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_head;
    logic                  fifo_push;
    logic                  rsp_pop;

    logic [CNT_WIDTH:0]    occupancy;
    logic                  credit_ok;
    logic                  accept;
    logic                  issue_write;
    logic                  issue_read;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            last_q      <= last_d;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue_read;
        last_d      = issue_last;
        case (state_q)
            IDLE: begin
                if (accept && !bus.cmd_wen && (bus.cmd_len != '0)) begin
                    state_d     = RBURST;
                    next_addr_d = bus.cmd_addr + ADDR_WIDTH'(1);
                    remaining_d = bus.cmd_len;
                end
            end
            RBURST: begin
                if (issue_read) begin
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        rsp_pop = !fifo_empty && bus.rsp_ready;

        // An issue now lands in the FIFO next cycle; an entry popped now is
        // gone by then, so a concurrent pop counts as free space. This keeps
        // one beat per cycle flowing with a two-entry FIFO.
        occupancy = (CNT_WIDTH+1)'(fifo_count) + (CNT_WIDTH+1)'(inflight_q)
                  - (CNT_WIDTH+1)'(rsp_pop);
        credit_ok = occupancy < (CNT_WIDTH+1)'(RSP_DEPTH_EFF);

        // Gated by reset_n so the port is quiet while reset is held.
        bus.cmd_ready = reset_n && (state_q == IDLE) && credit_ok;
        accept        = bus.cmd_valid && bus.cmd_ready;

        issue_write = accept && bus.cmd_wen;
        issue_read  = (accept && !bus.cmd_wen)
                   || (reset_n && (state_q == RBURST) && credit_ok);
        issue_addr  = accept ? bus.cmd_addr : next_addr_q;
        issue_last  = accept ? (bus.cmd_len == '0)
                             : (remaining_q == LEN_WIDTH'(1));
        if (!issue_read) begin
            issue_last = 1'b0;
        end

        bus.ram_cen  = issue_write || issue_read;
        bus.ram_wen  = issue_write;
        bus.ram_bwen = issue_write ? bus.cmd_bwen : '0;
        bus.ram_addr = (issue_write || issue_read) ? issue_addr : '0;
        bus.ram_din  = issue_write ? bus.cmd_wdata : '0;

        // RAM data for a read issued last cycle is captured now.
        fifo_push     = inflight_q && (!fifo_full || rsp_pop);
        bus.rsp_valid = !fifo_empty;
        bus.rsp_rdata = fifo_head[FIFO_WIDTH-1:1];
        bus.rsp_last  = fifo_head[0];
    end

    ram_rsp_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (RSP_DEPTH_EFF)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({bus.ram_dout, last_q}),
        .pop       (rsp_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule : ram_port_master
`default_nettype wire

// File: tb/tb_ram_port_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_master
//  Description : Directed self-checking bench for ram_port_master with a
//                behavioural byte-masked RAM (1-cycle registered read).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_master;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int LW = 4;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    ram_port_master_if #(.DATA_WIDTH(DW), .DEPTH(DP), .LEN_WIDTH(LW)) bus ();

    ram_port_master #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .LEN_WIDTH  (LW),
        .RSP_DEPTH  (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Initial RAM contents; location 3 starts cleared.
    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 3) ? 32'h0 : (32'hC0DE_0000 + 32'(a));
    endfunction

    // Behavioural RAM, reloaded while reset is held.
    logic [DW-1:0] mem [DP];
    logic [DW-1:0] dout_r;
    assign bus.ram_dout = dout_r;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DP; i++) mem[i] <= init_val(i);
        end else if (bus.ram_cen) begin
            if (bus.ram_wen) begin
                for (int b = 0; b < DW/8; b++)
                    if (bus.ram_bwen[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
            end else begin
                dout_r <= mem[bus.ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [3:0] be,
                           input int a, input int len, input logic [DW-1:0] wd);
        bus.cmd_valid = v;
        bus.cmd_wen   = w;
        bus.cmd_bwen  = be;
        bus.cmd_addr  = 4'(a);
        bus.cmd_len   = 4'(len);
        bus.cmd_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        int a1 [4];
        int cen2 [9];
        int adr2 [9];
        int hd2 [9];
        logic [DW-1:0] wv [4];
        n_vec = 0;
        n_err = 0;
        a1 = '{14, 15, 0, 1};
        cen2 = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        adr2 = '{14, 15, 0, 0, 0, 1, 0, 0, 0};
        hd2  = '{-1, -1, 14, 14, 14, 15, 0, 1, -1};
        wv   = '{32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF, 32'h0BAD_F00D};

        // ---------------- reset
        reset_n       = 1'b0;
        bus.rsp_ready = 1'b0;
        set_cmd(1'b1, 1'b0, 4'h0, 0, 0, '0);
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_ram_cen",   32'(bus.ram_cen),   32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        set_cmd(1'b0, 1'b0, 4'h0, 0, 0, '0);
        reset_n = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rel_ram_cen",   32'(bus.ram_cen),   32'd0);

        // ---------------- write addr 3
        @(negedge clock);
        set_cmd(1'b1, 1'b1, 4'b0101, 3, 0, 32'hAABB_CCDD);
        #1;
        check("wr_cen",  32'(bus.ram_cen),  32'd1);
        check("wr_wen",  32'(bus.ram_wen),  32'd1);
        check("wr_addr", 32'(bus.ram_addr), 32'd3);
        check("wr_bwen", 32'(bus.ram_bwen), 32'b0101);
        check("wr_din",  bus.ram_din,       32'hAABB_CCDD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            set_cmd(1'b0, 1'b0, 4'h0, 0, 0, '0);
            #1;
            check("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("wr_idle_cen", 32'(bus.ram_cen), 32'd0);
        end

        // ---------------- single read addr 3
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        set_cmd(1'b1, 1'b0, 4'h0, 3, 0, '0);
        #1;
        check("rd1_cen",  32'(bus.ram_cen),  32'd1);
        check("rd1_wen",  32'(bus.ram_wen),  32'd0);
        check("rd1_bwen", 32'(bus.ram_bwen), 32'd0);
        check("rd1_addr", 32'(bus.ram_addr), 32'd3);
        @(negedge clock);
        set_cmd(1'b0, 1'b0, 4'h0, 0, 0, '0);
        #1;
        check("rd1_n1_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock); #1;
        check("rd1_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd1_data",  bus.rsp_rdata,      32'h00BB_00DD);
        check("rd1_last",  32'(bus.rsp_last),  32'd1);
        @(negedge clock); #1;
        check("rd1_popped", 32'(bus.rsp_valid), 32'd0);

        // ---------------- burst 14, len 3, rsp_ready high
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            set_cmd(c == 0, 1'b0, 4'h0, 14, 3, '0);
            #1;
            check("b1_cen", 32'(bus.ram_cen), (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) check("b1_addr", 32'(bus.ram_addr), 32'(a1[c]));
            check("b1_cmd_ready", 32'(bus.cmd_ready), (c == 0 || c >= 4) ? 32'd1 : 32'd0);
            check("b1_valid", 32'(bus.rsp_valid), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) begin
                check("b1_data", bus.rsp_rdata, init_val(a1[c-2]));
                check("b1_last", 32'(bus.rsp_last), (c == 5) ? 32'd1 : 32'd0);
            end
        end

        // ---------------- same burst with back-pressure
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            set_cmd(c == 0, 1'b0, 4'h0, 14, 3, '0);
            bus.rsp_ready = (c >= 4);
            #1;
            check("b2_cen", 32'(bus.ram_cen), 32'(cen2[c]));
            if (cen2[c] == 1) check("b2_addr", 32'(bus.ram_addr), 32'(adr2[c]));
            check("b2_valid", 32'(bus.rsp_valid), (hd2[c] >= 0) ? 32'd1 : 32'd0);
            if (hd2[c] >= 0) begin
                check("b2_data", bus.rsp_rdata, init_val(hd2[c]));
                check("b2_last", 32'(bus.rsp_last), (c == 7) ? 32'd1 : 32'd0);
            end
        end

        // ---------------- reset in the middle of a burst
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            set_cmd(c == 0, 1'b0, 4'h0, 4, 7, '0);
        end
        #1;
        check("mr_pre_valid", 32'(bus.rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(bus.rsp_valid), 32'd0);
        check("mr_cen",   32'(bus.ram_cen),   32'd0);
        check("mr_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("mr_rel_ready", 32'(bus.cmd_ready), 32'd1);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            check("mr_no_stale", 32'(bus.rsp_valid), 32'd0);
            check("mr_no_issue", 32'(bus.ram_cen),   32'd0);
        end

        // ---------------- alternating write/read to addr 9
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c < 8) set_cmd(1'b1, (c % 2) == 0, 4'hF, 9, 0, wv[c/2]);
            else       set_cmd(1'b0, 1'b0, 4'h0, 0, 0, '0);
            #1;
            if (c < 8) begin
                check("alt_ready", 32'(bus.cmd_ready), 32'd1);
                check("alt_wen",   32'(bus.ram_wen),   (c % 2 == 0) ? 32'd1 : 32'd0);
            end
            check("alt_valid", 32'(bus.rsp_valid), (c >= 3 && c % 2 == 1) ? 32'd1 : 32'd0);
            if (c >= 3 && c % 2 == 1) check("alt_data", bus.rsp_rdata, wv[(c-3)/2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ram_port_master
`default_nettype wire
